permutation_round_ctrl: RTL and testbench
=========================================

// Module: permutation_round_ctrl
// PURPOSE
//  Sequencer for the iterated ASCON permutation datapath: constant addition, substitution
//  layer, diffusion layer and the 320-bit state register. One round is executed per clock.
//  On request it runs p^a (initialisation/finalisation) or p^b (data processing).
//  It drives the round index, the input-mux select and the state-register enable, and
//  signals completion with a one-cycle pulse.
// PARAMETERS
//  NB_ROUNDS_A  12  rounds executed when mode_i=0 (p^a); legal range 1..12
//  NB_ROUNDS_B  6   rounds executed when mode_i=1 (p^b); legal range 1..12
// PORTS
//  clock_i          in   1  system clock, rising edge
//  reset_i          in   1  asynchronous reset, active high
//  start_i          in   1  request to run one permutation; sampled in IDLE or DONE only
//  mode_i           in   1  0: run NB_ROUNDS_A rounds, 1: run NB_ROUNDS_B rounds; sampled with start_i
//  round_o          out  4  round-constant index fed to the constant-addition layer, 0..11
//  select_init_o    out  1  1: datapath input mux takes the external state, 0: takes the state register
//  en_reg_state_o   out  1  state register load enable, one round result captured per cycle
//  busy_o           out  1  high while rounds are executing
//  done_o           out  1  one-cycle pulse: state register holds the permuted state
// BEHAVIOUR
//  - Clock and reset: one clock, clock_i. reset_i is asynchronous and active high; it forces
//    the FSM to IDLE, the round counter to 0 and every output to 0 immediately,
//    independent of the clock. This applies mid-operation too; the aborted permutation is
//    discarded and no done_o is produced.
//  - FSM states: IDLE, ROUND, DONE. Registered state, round counter and first-round flag.
//    All outputs decode from registers, so there is no combinational path from start_i or
//    mode_i to any output.
//  - IDLE
//    - Outputs: all outputs 0.
//    - start_i=1: go to ROUND. The counter loads 12-N, where N is the mode-selected round
//      count. mode_i is latched. The first-round flag is set.
//  - ROUND
//    - Outputs: busy_o=1, en_reg_state_o=1, round_o=counter.
//    - select_init_o=1 only in the first ROUND cycle (flag set), then 0.
//    - Each cycle: counter+1 and the flag clears.
//    - When counter=11: go to DONE and do not increment.
//    - start_i and mode_i are ignored throughout ROUND.
//  - DONE
//    - Outputs: done_o=1, busy_o=0, en_reg_state_o=0, round_o=0.
//    - The state register keeps the result, so it stays valid until the next start.
//    - start_i=1: go directly to ROUND (back-to-back, same load as from IDLE).
//    - start_i=0: go to IDLE.
//  - Latency: with start_i sampled at edge k, the ROUND cycles are k+1..k+N and done_o is
//    high in cycle k+N+1. p12: done 13 cycles after start. p6: 7 cycles after start.
//  - Round indices run 12-N .. 11 inclusive, i.e. the last N ASCON round constants.
//  - Counter arithmetic is 4-bit unsigned. It never exceeds 11 and never wraps.
//  - Elaboration check: a parameter outside 1..12 raises a $error.
// TESTING
//  1 Assert reset_i for 2 cycles -> all outputs 0, FSM in IDLE.
//    Release reset and hold start_i=0 for 5 cycles -> outputs stay 0.
//  2 Pulse start_i with mode_i=0 -> round_o=0,1,..,11 on 12 consecutive cycles,
//    select_init_o=1 only on the first, en_reg_state_o=1 for 12 cycles, busy_o=1 for 12,
//    done_o pulse on cycle 13. With the full datapath, the final state equals the
//    golden-model p12 output.
//  3 Pulse start_i with mode_i=1 -> round_o=6..11 over 6 cycles, done_o on cycle 7,
//    en_reg_state_o count=6.
//  4 Hold start_i=1 continuously with mode_i=1 -> DONE is followed immediately by ROUND:
//    done_o pulses every 7 cycles, round_o restarts at 6, select_init_o=1 on each restart.
//  5 During a p12 run, toggle start_i and flip mode_i at round_o=3 -> the run is
//    unaffected: still 12 rounds ending at 11, one done_o.
//  6 Assert reset_i asynchronously (mid-cycle) while round_o=5 -> all outputs 0 before the
//    next clock edge, no done_o. A following start with mode_i=0 restarts at round_o=0.

Source files
------------

// File: rtl/permutation_round_ctrl.sv
// Round sequencer for the iterated ASCON permutation: runs p^a or p^b, one round per clock,
// and drives round index, input-mux select and state-register enable.
module permutation_round_ctrl #(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
    output logic [3:0] round_o,
    output logic       select_init_o,
    output logic       en_reg_state_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;
    // Running the last N constants of the 12-round schedule means starting at index 12-N.
    localparam logic [3:0] LOAD_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] LOAD_B = 4'(12 - NB_ROUNDS_B);

    generate
        if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12) begin : g_bad_rounds_a
            $error("permutation_round_ctrl: NB_ROUNDS_A must be in 1..12");
        end
        if (NB_ROUNDS_B < 1 || NB_ROUNDS_B > 12) begin : g_bad_rounds_b
            $error("permutation_round_ctrl: NB_ROUNDS_B must be in 1..12");
        end
    endgenerate

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       first_q;
    logic       mode_q;
    logic [3:0] load_value;

    assign load_value = mode_i ? LOAD_B : LOAD_A;

    // Outputs are registered alongside the state so nothing on them depends combinationally
    // on start_i or mode_i.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            first_q        <= 1'b0;
            mode_q         <= 1'b0;
            round_o        <= '0;
            select_init_o  <= 1'b0;
            en_reg_state_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q        <= ROUND;
                        cnt_q          <= load_value;
                        first_q        <= 1'b1;
                        mode_q         <= mode_i;
                        round_o        <= load_value;
                        select_init_o  <= 1'b1;
                        en_reg_state_o <= 1'b1;
                        busy_o         <= 1'b1;
                        done_o         <= 1'b0;
                    end else begin
                        state_q        <= IDLE;
                        first_q        <= 1'b0;
                        round_o        <= '0;
                        select_init_o  <= 1'b0;
                        en_reg_state_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b0;
                    end
                end
                ROUND: begin
                    first_q <= 1'b0;
                    if (cnt_q == LAST_ROUND) begin
                        state_q        <= DONE;
                        round_o        <= '0;
                        select_init_o  <= 1'b0;
                        en_reg_state_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                    end else begin
                        cnt_q          <= cnt_q + 4'd1;
                        round_o        <= cnt_q + 4'd1;
                        select_init_o  <= 1'b0;
                        en_reg_state_o <= 1'b1;
                        busy_o         <= 1'b1;
                        done_o         <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    cnt_q          <= '0;
                    first_q        <= 1'b0;
                    round_o        <= '0;
                    select_init_o  <= 1'b0;
                    en_reg_state_o <= 1'b0;
                    busy_o         <= 1'b0;
                    done_o         <= 1'b0;
                end
            endcase
        end
    end

    // The counter stays within the window of the mode latched at start and never passes 11.
    a_round_window: assert property (@(posedge clock_i) disable iff (reset_i)
        (state_q == ROUND) |-> (cnt_q >= (mode_q ? LOAD_B : LOAD_A)) && (cnt_q <= LAST_ROUND));

    a_select_first: assert property (@(posedge clock_i) disable iff (reset_i)
        (state_q == ROUND) |-> (select_init_o == first_q));

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Scoreboard bench for permutation_round_ctrl: stimulus queues expected output words,
// a negedge monitor pops and compares whenever the DUT is busy or signalling done.
module tb_permutation_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] round;
    logic       sel_init;
    logic       en_state;
    logic       busy;
    logic       done;

    int unsigned vectors = 0;
    int unsigned fails = 0;

    // Expected word layout: {round[3:0], select_init, en_reg_state, busy, done}
    logic [7:0] sb[$];

    permutation_round_ctrl #(
        .NB_ROUNDS_A(12),
        .NB_ROUNDS_B(6)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start),
        .mode_i        (mode),
        .round_o       (round),
        .select_init_o (sel_init),
        .en_reg_state_o(en_state),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] word(input logic [3:0] r, input logic s, input logic e,
                                        input logic b, input logic d);
        return {r, s, e, b, d};
    endfunction

    function automatic logic [7:0] got_word();
        return {round, sel_init, en_state, busy, done};
    endfunction

    // Push the full expected trace of one permutation: N round cycles then the done pulse.
    task automatic expect_run(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back(word(4'(12 - n + i), (i == 0), 1'b1, 1'b1, 1'b0));
        sb.push_back(word(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (got_word() !== 8'h00) begin
            fails++;
            $display("FAIL %s: got %h expected 00", name, got_word());
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int cycles = 0;
        while (sb.size() != 0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected outputs never seen within %0d cycles",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (busy || done)) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got %h expected none", got_word());
            end else begin
                logic [7:0] exp_w;
                exp_w = sb.pop_front();
                if (got_word() !== exp_w) begin
                    fails++;
                    $display("FAIL trace: got %h expected %h", got_word(), exp_w);
                end
            end
        end
    end

    initial begin
        // 1: reset and idle
        @(negedge clk);
        rst = 1'b1;
        #1 check_idle("reset_async");
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("idle_no_start");
        end

        // 2: single p12
        start = 1'b1;
        mode  = 1'b0;
        expect_run(12);
        @(negedge clk);
        start = 1'b0;
        wait_drain("p12_single", 30);
        @(negedge clk);
        check_idle("idle_after_p12");

        // 3: single p6
        start = 1'b1;
        mode  = 1'b1;
        expect_run(6);
        @(negedge clk);
        start = 1'b0;
        wait_drain("p6_single", 20);
        @(negedge clk);
        check_idle("idle_after_p6");

        // 4: start held high, three back-to-back p6 runs; drop start during the third done
        start = 1'b1;
        mode  = 1'b1;
        for (int i = 0; i < 3; i++) expect_run(6);
        repeat (21) @(negedge clk);
        start = 1'b0;
        wait_drain("p6_back_to_back", 10);
        @(negedge clk);
        check_idle("idle_after_b2b");

        // 5: start/mode activity mid-run is ignored
        start = 1'b1;
        mode  = 1'b0;
        expect_run(12);
        repeat (4) @(negedge clk);
        vectors++;
        if (round !== 4'd3) begin
            fails++;
            $display("FAIL mid_run_round: got %0d expected 3", round);
        end
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = 1'b1;
        @(negedge clk);
        mode = 1'b0;
        wait_drain("p12_ignore_inputs", 20);
        @(negedge clk);
        check_idle("idle_after_ignore");

        // 6: asynchronous reset mid-run at round 5, then clean restart
        start = 1'b1;
        mode  = 1'b0;
        expect_run(12);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (round !== 4'd5) begin
            fails++;
            $display("FAIL pre_abort_round: got %0d expected 5", round);
        end
        #2 rst = 1'b1;
        sb.delete();
        #1 check_idle("abort_async");
        repeat (2) @(negedge clk);
        check_idle("abort_held");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("no_done_after_abort");
        end
        start = 1'b1;
        mode  = 1'b0;
        expect_run(12);
        @(negedge clk);
        start = 1'b0;
        wait_drain("p12_after_abort", 30);
        @(negedge clk);
        check_idle("idle_final");

        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
